chan_trig_unit: RTL and testbench

Parametrised channel trigger unit for the logic-analyzer digital core. It synchronises the NUM_CH pairs of high/low comparator inputs and evaluates a per-channel 5-bit trigger condition (don't-care, low level, high level, negedge, posedge) for each channel. It then ANDs all channels with the protocol trigger and the armed qualifier, and requires the combined match to hold for a programmable number of consecutive samples. The fired trigger is latched until it is explicitly cleared. It replaces the fixed 5-channel, single-sample trigger path feeding the capture controller.

---
 rtl/trig_pkg.sv | 10 +
 rtl/chan_trig_cell.sv | 29 ++
 rtl/chan_trig_unit.sv | 81 ++++++++
 tb/tb_chan_trig_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// trig_pkg: shared types and constants for the channel trigger unit
package trig_pkg;
    typedef logic [4:0] ch_cfg_t;
    localparam int CFG_DC   = 0;
    localparam int CFG_LOW  = 1;
    localparam int CFG_HIGH = 2;
    localparam int CFG_NEG  = 3;
    localparam int CFG_POS  = 4;
    typedef enum logic [1:0] {IDLE, QUAL, TRIGD} trig_state_t;
endpackage

// File: rtl/chan_trig_cell.sv
// chan_trig_cell: one channel's synchronisers, delay flops and registered trigger condition
// Ports: clk/rst_n, h/l async comparator inputs, cfg condition enables, trig registered match
module chan_trig_cell
    import trig_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    h,
    input  logic    l,
    input  ch_cfg_t cfg,
    output logic    trig
);
    logic h1, l1, sh, sl, ph, pl, cond;
    always_comb cond = cfg[CFG_DC] | (cfg[CFG_LOW] & ~sl) | (cfg[CFG_HIGH] & sh)
                     | (cfg[CFG_NEG] & pl & ~sl) | (cfg[CFG_POS] & sh & ~ph);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {h1, l1, sh, sl, ph, pl, trig} <= '0;
        end else begin
            h1   <= h;
            l1   <= l;
            sh   <= h1;
            sl   <= l1;
            ph   <= sh;
            pl   <= sl;
            trig <= cond;
        end
    end
endmodule

// File: rtl/chan_trig_unit.sv
// chan_trig_unit: per-channel trigger evaluation, consecutive-match qualifier and latched trigger
// Ports: clk/rst_n, chH/chL comparator inputs, ch_cfg 5 bits per channel, prot_trig/armed qualifiers,
//        match_cnt samples required, clr_trig clear; ch_trig, triggered, trig_pulse outputs
module chan_trig_unit
    import trig_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   chH,
    input  logic [NUM_CH-1:0]   chL,
    input  logic [5*NUM_CH-1:0] ch_cfg,
    input  logic                prot_trig,
    input  logic                armed,
    input  logic [CNT_W-1:0]    match_cnt,
    input  logic                clr_trig,
    output logic [NUM_CH-1:0]   ch_trig,
    output logic                triggered,
    output logic                trig_pulse
);
    trig_state_t      state;
    logic [CNT_W-1:0] cnt, thr;
    logic             all_match, hit;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        chan_trig_cell u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .h    (chH[i]),
            .l    (chL[i]),
            .cfg  (ch_cfg[5*i +: 5]),
            .trig (ch_trig[i])
        );
    end
    always_comb begin
        all_match = &ch_trig & prot_trig & armed;
        thr       = (match_cnt == '0) ? CNT_W'(1) : match_cnt;
        // widened so cnt+1 cannot wrap before the compare
        hit       = ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, thr};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            triggered  <= 1'b0;
            trig_pulse <= 1'b0;
        end else begin
            trig_pulse <= 1'b0;
            // clear takes priority over any fire in the same cycle
            if (clr_trig) begin
                cnt <= '0;
                if (state == TRIGD) begin
                    state     <= IDLE;
                    triggered <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (armed) state <= QUAL;
                    end
                    QUAL: begin
                        if (!armed) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (all_match && hit) begin
                            state      <= TRIGD;
                            triggered  <= 1'b1;
                            trig_pulse <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            cnt <= all_match ? cnt + CNT_W'(1) : '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_chan_trig_unit.sv
// tb_chan_trig_unit: directed self-checking bench for chan_trig_unit
module tb_chan_trig_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  chH, chL;
    logic [24:0] ch_cfg;
    logic        prot_trig, armed, clr_trig;
    logic [7:0]  match_cnt;
    logic [4:0]  ch_trig;
    logic        triggered, trig_pulse;
    int          vec = 0;
    int          errs = 0;

    chan_trig_unit #(.NUM_CH(5), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .chH       (chH),
        .chL       (chL),
        .ch_cfg    (ch_cfg),
        .prot_trig (prot_trig),
        .armed     (armed),
        .match_cnt (match_cnt),
        .clr_trig  (clr_trig),
        .ch_trig   (ch_trig),
        .triggered (triggered),
        .trig_pulse(trig_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; chH = '0; chL = '0; ch_cfg = '0;
        prot_trig = 1'b1; armed = 1'b0; clr_trig = 1'b0; match_cnt = 8'd1;
        tick(2);
        chk("rst_ch_trig", 32'(ch_trig), 32'h0);
        chk("rst_triggered", 32'(triggered), 32'h0);
        chk("rst_pulse", 32'(trig_pulse), 32'h0);
        rst_n = 1'b1;
        // all don't-care, single-sample fire
        ch_cfg = {5{5'h01}};
        tick(4);
        chk("dc_ch_trig", 32'(ch_trig), 32'h1F);
        armed = 1'b1;
        tick(1);
        chk("dc_idle_to_qual", 32'(triggered), 32'h0);
        tick(1);
        chk("dc_fire", 32'(triggered), 32'h1);
        chk("dc_pulse", 32'(trig_pulse), 32'h1);
        tick(1);
        chk("dc_pulse_width", 32'(trig_pulse), 32'h0);
        chk("dc_latched", 32'(triggered), 32'h1);
        armed = 1'b0;
        tick(3);
        chk("latched_unarmed", 32'(triggered), 32'h1);
        clr_trig = 1'b1;
        tick(1);
        chk("clr", 32'(triggered), 32'h0);
        clr_trig = 1'b0;
        // posedge on channel 0
        ch_cfg = {5'h01, 5'h01, 5'h01, 5'h01, 5'h10};
        tick(3);
        chk("pos_idle_ch", 32'(ch_trig), 32'h1E);
        armed = 1'b1;
        tick(1);
        chH = 5'h01;
        tick(2);
        chk("pos_k2", 32'(ch_trig), 32'h1E);
        tick(1);
        chk("pos_k3", 32'(ch_trig), 32'h1F);
        chk("pos_k3_trig", 32'(triggered), 32'h0);
        tick(1);
        chk("pos_k4", 32'(ch_trig), 32'h1E);
        chk("pos_k4_trig", 32'(triggered), 32'h1);
        chk("pos_k4_pulse", 32'(trig_pulse), 32'h1);
        tick(5);
        chk("pos_held_pulse", 32'(trig_pulse), 32'h0);
        clr_trig = 1'b1;
        tick(1);
        clr_trig = 1'b0;
        tick(5);
        chk("pos_no_repeat", 32'(triggered), 32'h0);
        // high level, four consecutive samples
        armed = 1'b0; ch_cfg = {5{5'h04}}; chH = 5'h1F; match_cnt = 8'd4;
        tick(4);
        chk("hi_ch_trig", 32'(ch_trig), 32'h1F);
        armed = 1'b1;
        tick(4);
        chk("hi_m4_early", 32'(triggered), 32'h0);
        tick(1);
        chk("hi_m4_fire", 32'(triggered), 32'h1);
        chk("hi_m4_pulse", 32'(trig_pulse), 32'h1);
        clr_trig = 1'b1;
        tick(1);
        chk("hi_clr", 32'(triggered), 32'h0);
        clr_trig = 1'b0;
        tick(1);
        chH = 5'h1B;
        tick(1);
        chH = 5'h1F;
        tick(2);
        chk("gap_ch_trig", 32'(ch_trig), 32'h1B);
        chk("gap_no_fire", 32'(triggered), 32'h0);
        tick(1);
        chk("gap_recover", 32'(ch_trig), 32'h1F);
        tick(3);
        chk("gap_early", 32'(triggered), 32'h0);
        tick(1);
        chk("gap_fire", 32'(triggered), 32'h1);
        // channel with empty config blocks the trigger
        clr_trig = 1'b1;
        tick(1);
        clr_trig = 1'b0;
        ch_cfg = {5'h01, 5'h00, 5'h01, 5'h01, 5'h01}; match_cnt = 8'd1;
        tick(1000);
        chk("cfg0_ch_trig", 32'(ch_trig), 32'h17);
        chk("cfg0_blocked", 32'(triggered), 32'h0);
        ch_cfg = {5{5'h01}}; prot_trig = 1'b0;
        tick(50);
        chk("prot_ch_trig", 32'(ch_trig), 32'h1F);
        chk("prot_blocked", 32'(triggered), 32'h0);
        // clear beats a simultaneous fire and zeroes the counter
        match_cnt = 8'd2; prot_trig = 1'b1;
        tick(1);
        clr_trig = 1'b1;
        tick(1);
        chk("clr_vs_fire", 32'(triggered), 32'h0);
        chk("clr_vs_fire_pulse", 32'(trig_pulse), 32'h0);
        clr_trig = 1'b0;
        tick(1);
        chk("clr_cnt_zero", 32'(triggered), 32'h0);
        tick(1);
        chk("clr_then_fire", 32'(triggered), 32'h1);
        chk("clr_then_pulse", 32'(trig_pulse), 32'h1);
        // live lowering of match_cnt, zero treated as one
        clr_trig = 1'b1;
        tick(1);
        clr_trig = 1'b0; match_cnt = 8'd8;
        tick(4);
        chk("live_wait", 32'(triggered), 32'h0);
        match_cnt = 8'd0;
        tick(1);
        chk("live_fire", 32'(triggered), 32'h1);
        chk("live_pulse", 32'(trig_pulse), 32'h1);
        // asynchronous reset mid-qualification
        clr_trig = 1'b1;
        tick(1);
        clr_trig = 1'b0; match_cnt = 8'd8; ch_cfg = {5{5'h04}};
        tick(4);
        chk("pre_rst_ch_trig", 32'(ch_trig), 32'h1F);
        chk("pre_rst_trig", 32'(triggered), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("arst_ch_trig", 32'(ch_trig), 32'h0);
        chk("arst_triggered", 32'(triggered), 32'h0);
        chk("arst_pulse", 32'(trig_pulse), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_2clk", 32'(ch_trig), 32'h0);
        tick(1);
        chk("post_rst_3clk", 32'(ch_trig), 32'h1F);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
